seven_segment_capture: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display driver. It samples the active-low segment bus and active-low digit-select bus, and rebuilds the 4-digit decimal value shown on the display. It outputs that value as a 16-bit binary number with a one-cycle valid pulse. It sits on the self-check/debug path: it loops the display outputs back into logic so the bench (or on-chip checker) can compare the displayed score against the source value.

---
 rtl/seven_segment_capture_if.sv | 32 +++
 rtl/seven_segment_capture.sv | 235 +++++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_capture_if.sv
// ----------------------------------------------------------------------------
// seven_segment_capture_if
// Bundles the multiplexed seven-segment display bus (observed side) and the
// reconstructed-value outputs of seven_segment_capture.
//   display : segment bus, active-low, bit6=g ... bit0=a
//   digit   : digit enables, active-low one-hot, bit0 = ones position
//   nums    : reconstructed binary value 0..9999, zero-extended
//   bcd     : digits of the last good frame {thousands,hundreds,tens,ones}
//   valid   : one-cycle pulse when a frame completes
//   error   : last completed frame held an undecodable digit
//   stale   : display went quiet long enough to discard a partial frame
// master drives the display side; slave is the capture block.
// ----------------------------------------------------------------------------
interface seven_segment_capture_if;
  logic [6:0]  display;
  logic [3:0]  digit;
  logic [15:0] nums;
  logic [15:0] bcd;
  logic        valid;
  logic        error;
  logic        stale;

  modport master (
    output display, digit,
    input  nums, bcd, valid, error, stale
  );

  modport slave (
    input  display, digit,
    output nums, bcd, valid, error, stale
  );
endinterface

// File: rtl/seven_segment_capture.sv
// ----------------------------------------------------------------------------
// seven_segment_capture
// Watches a multiplexed, active-low seven-segment display and rebuilds the
// 4-digit decimal value it shows, emitting it as binary with a valid pulse.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : seven_segment_capture_if.slave (display/digit in, results out)
// Parameters:
//   SETTLE_CYCLES  : cycles a {digit,display} pair must be stable (min 2)
//   TIMEOUT_CYCLES : sample-free cycles before a partial frame is dropped
// ----------------------------------------------------------------------------
module seven_segment_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_segment_capture_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  // ---------------- segment / position decode ----------------
  logic       code_ok;
  logic [3:0] code_val;
  logic       pos_ok;
  logic [1:0] pos_idx;

  always_comb begin
    code_ok  = 1'b1;
    code_val = 4'd0;
    case (bus.display)
      7'b1000000: code_val = 4'd0;
      7'b1111001: code_val = 4'd1;
      7'b0100100: code_val = 4'd2;
      7'b0110000: code_val = 4'd3;
      7'b0011001: code_val = 4'd4;
      7'b0010010: code_val = 4'd5;
      7'b0000010: code_val = 4'd6;
      7'b1111000: code_val = 4'd7;
      7'b0000000: code_val = 4'd8;
      7'b0010000: code_val = 4'd9;
      default:    code_ok  = 1'b0;
    endcase
  end

  always_comb begin
    pos_ok  = 1'b1;
    pos_idx = 2'd0;
    case (bus.digit)
      4'b1110: pos_idx = 2'd0;
      4'b1101: pos_idx = 2'd1;
      4'b1011: pos_idx = 2'd2;
      4'b0111: pos_idx = 2'd3;
      default: pos_ok  = 1'b0;
    endcase
  end

  // ---------------- settle tracking ----------------
  logic [10:0]   pair_q;
  logic [SW-1:0] settle_q, settle_d;
  logic          sampled_q, sampled_d;
  logic          same_pair;
  logic          sample_fire;

  assign same_pair   = ({bus.digit, bus.display} == pair_q);
  // One sample per dwell: sampled_q blocks repeats until the pair changes.
  assign sample_fire = pos_ok && same_pair && (settle_q == SETTLE_MAX) && !sampled_q;

  always_comb begin
    settle_d  = settle_q;
    sampled_d = sampled_q;
    if (!pos_ok || !same_pair) begin
      settle_d  = '0;
      sampled_d = 1'b0;
    end else begin
      if (settle_q != SETTLE_MAX) settle_d = settle_q + 1'b1;
      if (sample_fire)            sampled_d = 1'b1;
    end
  end

  // ---------------- timeout ----------------
  logic [TW-1:0] timeout_q, timeout_d;
  logic          timeout_fire;

  // A sample on the same edge wins over the timeout.
  assign timeout_fire = !sample_fire && (timeout_q == TIMEOUT_MAX);
  assign timeout_d    = (sample_fire || timeout_fire) ? '0 : timeout_q + 1'b1;

  // ---------------- live frame: slots, seen mask, bad flag ----------------
  state_t     state_q, state_d;
  logic [3:0] seen_q, seen_d;
  logic       bad_q, bad_d;
  logic       frame_take;
  logic [15:0] slots_w;

  // A completed frame waits in seen_q until the converter is back in IDLE.
  assign frame_take = (state_q == IDLE) && (seen_q == 4'b1111);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic [3:0] slot_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_q <= 4'd0;
        end else if (sample_fire && code_ok && (pos_idx == 2'(gi))) begin
          slot_q <= code_val;
        end
      end
      assign slots_w[gi*4 +: 4] = slot_q;
    end
  endgenerate

  always_comb begin
    seen_d = seen_q;
    bad_d  = bad_q;
    if (frame_take || timeout_fire) begin
      seen_d = 4'b0000;
      bad_d  = 1'b0;
    end
    // A sample landing on the snapshot edge belongs to the next frame.
    if (sample_fire) begin
      seen_d[pos_idx] = 1'b1;
      if (!code_ok) bad_d = 1'b1;
    end
  end

  // ---------------- conversion FSM ----------------
  logic [15:0] shadow_q, shadow_d;
  logic        shadow_bad_q, shadow_bad_d;
  logic [13:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] nums_q, nums_d, bcd_q, bcd_d;
  logic        valid_q, valid_d, error_q, error_d, stale_q, stale_d;
  logic [1:0]  sel_pos;
  logic [3:0]  conv_digit;

  // Conversion walks from the thousands slot down to the ones slot.
  assign sel_pos    = 2'd3 - idx_q;
  assign conv_digit = shadow_q[sel_pos*4 +: 4];

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    shadow_bad_d = shadow_bad_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    nums_d       = nums_q;
    bcd_d        = bcd_q;
    valid_d      = 1'b0;
    error_d      = error_q;
    stale_d      = stale_q;
    case (state_q)
      IDLE: begin
        if (frame_take) begin
          shadow_d     = slots_w;
          shadow_bad_d = bad_q;
          acc_d        = '0;
          idx_d        = 2'd0;
          state_d      = CONV;
        end
      end
      CONV: begin
        acc_d = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0} + {10'd0, conv_digit};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (!shadow_bad_q) begin
          nums_d  = {2'b00, acc_q};
          bcd_d   = shadow_q;
          error_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
        valid_d = 1'b1;
        stale_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_fire) stale_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q       <= '0;
      settle_q     <= '0;
      sampled_q    <= 1'b0;
      timeout_q    <= '0;
      seen_q       <= 4'b0000;
      bad_q        <= 1'b0;
      state_q      <= IDLE;
      shadow_q     <= '0;
      shadow_bad_q <= 1'b0;
      acc_q        <= '0;
      idx_q        <= 2'd0;
      nums_q       <= '0;
      bcd_q        <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      pair_q       <= {bus.digit, bus.display};
      settle_q     <= settle_d;
      sampled_q    <= sampled_d;
      timeout_q    <= timeout_d;
      seen_q       <= seen_d;
      bad_q        <= bad_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_bad_q <= shadow_bad_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      nums_q       <= nums_d;
      bcd_q        <= bcd_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      stale_q      <= stale_d;
    end
  end

  assign bus.nums  = nums_q;
  assign bus.bcd   = bcd_q;
  assign bus.valid = valid_q;
  assign bus.error = error_q;
  assign bus.stale = stale_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// ----------------------------------------------------------------------------
// tb_seven_segment_capture
// Directed frames on the display bus; expected results are queued when a
// frame is issued and compared by a monitor whenever valid pulses.
// ----------------------------------------------------------------------------
module tb_seven_segment_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_capture_if bus ();

  seven_segment_capture #(
    .SETTLE_CYCLES (16),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int nums;
    int bcd;
    int err;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pos3_cyc = 0;

  // Pair applied at cycle C is sampled on edge C+17; valid appears after C+23.
  localparam int LAT = 23;
  localparam logic [6:0] BLANK = 7'b1111111;

  always @(posedge clk) cyc++;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.digit   = 4'b1111;
    bus.display = BLANK;
    tick(n);
  endtask

  task automatic drive(input int pos, input logic [6:0] code, input int n);
    logic [3:0] one;
    one = 4'b0001 << pos;
    bus.digit   = ~one;
    bus.display = code;
    if (pos == 3) pos3_cyc = cyc;
    tick(n);
  endtask

  task automatic frame(input logic [6:0] c3, input logic [6:0] c2,
                       input logic [6:0] c1, input logic [6:0] c0);
    drive(0, c0, 20);
    drive(1, c1, 20);
    drive(2, c2, 20);
    drive(3, c3, 20);
  endtask

  task automatic push(input int n, input int b, input int e, input int lat);
    exp_t x;
    x.nums = n; x.bcd = b; x.err = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_nums"},  int'(bus.nums),  0);
    chk({tag, "_bcd"},   int'(bus.bcd),   0);
    chk({tag, "_valid"}, int'(bus.valid), 0);
    chk({tag, "_error"}, int'(bus.error), 0);
    chk({tag, "_stale"}, int'(bus.stale), 0);
  endtask

  // Monitor: every valid pulse pops and checks one expected frame.
  always @(negedge clk) begin
    if (bus.valid) begin
      $display("valid at cycle %0d: nums=%0d bcd=%04h error=%0b stale=%0b",
               cyc, bus.nums, bus.bcd, bus.error, bus.stale);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got nums=%0d required no valid", bus.nums);
      end else begin
        mon_e = exp_q.pop_front();
        chk("nums",  int'(bus.nums),  mon_e.nums);
        chk("bcd",   int'(bus.bcd),   mon_e.bcd);
        chk("error", int'(bus.error), mon_e.err);
        chk("stale", int'(bus.stale), 0);
        if (mon_e.lat != 0) chk("latency", cyc - pos3_cyc, mon_e.lat);
      end
    end
  end

  initial begin
    bus.digit   = 4'b1111;
    bus.display = BLANK;
    rst = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    idle(5);

    // 1234 with latency check
    push(1234, 16'h1234, 0, LAT);
    frame(seg(1), seg(2), seg(3), seg(4));
    idle(30);

    // 9999 then 0000
    push(9999, 16'h9999, 0, 0);
    frame(seg(9), seg(9), seg(9), seg(9));
    idle(30);
    push(0, 16'h0000, 0, 0);
    frame(seg(0), seg(0), seg(0), seg(0));
    idle(30);

    // pos1 held too briefly: frame must not complete
    drive(0, seg(1), 20);
    drive(1, seg(9), 10);
    drive(2, seg(3), 20);
    drive(3, seg(4), 20);
    idle(30);
    chk("short_dwell_pending", exp_q.size(), 0);
    push(4321, 16'h4321, 0, 0);
    drive(1, seg(2), 20);
    idle(30);

    // blank digit -> error, value held; then good frame clears error
    push(4321, 16'h4321, 1, 0);
    frame(seg(9), BLANK, seg(6), seg(5));
    idle(30);
    push(5678, 16'h5678, 0, 0);
    frame(seg(5), seg(6), seg(7), seg(8));
    idle(30);

    // timeout with partial frame
    drive(0, seg(2), 20);
    drive(1, seg(4), 20);
    drive(2, seg(0), 20);
    chk("stale_before_timeout", int'(bus.stale), 0);
    idle(250);
    chk("stale_after_timeout", int'(bus.stale), 1);
    push(42, 16'h0042, 0, 0);
    frame(seg(0), seg(0), seg(4), seg(2));
    idle(30);

    // reset two cycles into CONV aborts the conversion
    drive(0, seg(8), 20);
    drive(1, seg(8), 20);
    drive(2, seg(8), 20);
    drive(3, seg(8), 19);
    bus.digit   = 4'b1111;
    bus.display = BLANK;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_zero("midconv_reset");
    idle(30);
    push(7, 16'h0007, 0, 0);
    frame(seg(0), seg(0), seg(0), seg(7));
    idle(30);

    // drain: bounded wait for outstanding expectations
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    chk("pending_at_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
